hpdcache_cmoh_flush: RTL and testbench

- Second-generation cache-management-operation handler for HPDcache, located between the CMO request port and the directory/flush datapath.
- Adds flush (dirty writeback) operations, a response handshake with error reporting, and full parametrisation of geometry.
- Executes fence, invalidate (by nline, by set, all), flush (by nline, all) and flush+invalidate-all.
- Iterates sets and ways with internal counters.

---
 rtl/hpdcache_cmoh_flush.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_hpdcache_cmoh_flush.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_cmoh_flush.sv
// ----------------------------------------------------------------------------
// hpdcache_cmoh_flush
//   Cache-management-operation handler for HPDcache. Accepts one CMO request
//   at a time (fence, invalidate by nline/set/all, flush by nline/all,
//   flush+invalidate all). It drains the other cache units, walks the
//   directory set by set, issues per-way writeback requests to the flush
//   unit and invalidation strobes to the directory, and finally answers
//   with a response (error flag set for the illegal op code).
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   *_empty_i                     idle status of wbuf/mshr/rtab/ctrl/flush
//   req_valid_i/req_ready_o       CMO request handshake
//   req_op_i/req_addr_i/req_way_i request op code, address, INVAL_SET mask
//   req_wait_o                    handler is waiting for other units
//   rsp_valid_o/rsp_ready_i       completion handshake, rsp_error_o flag
//   wbuf_flush_all_o              write-buffer flush-all request (fence)
//   dir_check_*                   directory lookup (result one cycle later)
//   dir_inval_*                   directory invalidation strobe
//   flush_req_*                   writeback request towards flush unit
// ----------------------------------------------------------------------------
module hpdcache_cmoh_flush #(
  parameter int unsigned WAYS        = 4,
  parameter int unsigned SETS        = 64,
  parameter int unsigned CL_OFFSET_W = 6,
  parameter int unsigned TAG_W       = 20,
  localparam int unsigned SET_W      = $clog2(SETS),
  localparam int unsigned ADDR_W     = TAG_W + SET_W + CL_OFFSET_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              wbuf_empty_i,
  input  logic              mshr_empty_i,
  input  logic              rtab_empty_i,
  input  logic              ctrl_empty_i,
  input  logic              flush_empty_i,

  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [WAYS-1:0]   req_way_i,
  output logic              req_wait_o,

  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_error_o,

  output logic              wbuf_flush_all_o,

  output logic              dir_check_o,
  output logic [SET_W-1:0]  dir_check_set_o,
  output logic [TAG_W-1:0]  dir_check_tag_o,
  input  logic [WAYS-1:0]   dir_check_hit_way_i,
  input  logic [WAYS-1:0]   dir_check_dirty_i,

  output logic              dir_inval_o,
  output logic [SET_W-1:0]  dir_inval_set_o,
  output logic [WAYS-1:0]   dir_inval_way_o,

  output logic              flush_req_valid_o,
  input  logic              flush_req_ready_i,
  output logic [SET_W-1:0]  flush_req_set_o,
  output logic [WAYS-1:0]   flush_req_way_o,
  output logic              flush_req_inval_o
);

  typedef enum logic [2:0] {
    OP_FENCE           = 3'd0,
    OP_INVAL_NLINE     = 3'd1,
    OP_INVAL_SET       = 3'd2,
    OP_INVAL_ALL       = 3'd3,
    OP_FLUSH_NLINE     = 3'd4,
    OP_FLUSH_ALL       = 3'd5,
    OP_FLUSH_INVAL_ALL = 3'd6,
    OP_ILLEGAL         = 3'd7
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FENCE_WAIT,
    ST_DRAIN,
    ST_CHECK,
    ST_EVAL,
    ST_FLUSH,
    ST_INVAL,
    ST_FLUSH_DRAIN,
    ST_RSP
  } state_e;

  state_e                    state_q;
  op_e                       op_q;
  logic [TAG_W+SET_W-1:0]    addr_q;    // line address (offset dropped)
  logic [WAYS-1:0]           mask_q;
  logic [WAYS-1:0]           way_q;
  logic [SET_W-1:0]          set_cnt_q;
  logic                      error_q;

  // The byte offset inside a cacheline is irrelevant to every CMO.
  logic unused_addr_offset;
  assign unused_addr_offset = ^req_addr_i[CL_OFFSET_W-1:0];

  logic [SET_W-1:0] addr_set;
  logic [TAG_W-1:0] addr_tag;
  assign addr_set = addr_q[SET_W-1:0];
  assign addr_tag = addr_q[TAG_W+SET_W-1:SET_W];

  logic is_nline;
  logic last_set;
  assign is_nline = (op_q == OP_INVAL_NLINE) || (op_q == OP_FLUSH_NLINE);
  assign last_set = (set_cnt_q == SET_W'(SETS - 1));

  // Lowest set bit of the way register and what remains after serving it.
  logic [WAYS-1:0] way_lsb;
  logic [WAYS-1:0] way_rem;
  assign way_lsb = way_q & (~way_q + WAYS'(1));
  assign way_rem = way_q & ~way_lsb;

  logic [SET_W-1:0] walk_set;
  assign walk_set = is_nline ? addr_set : set_cnt_q;

  // Set-advance step: either finish the walk or move to the next set.
  state_e adv_state;
  logic   adv_inc;
  always_comb begin
    adv_state = ST_FLUSH_DRAIN;
    adv_inc   = 1'b0;
    if (last_set) begin
      adv_state = (op_q == OP_INVAL_ALL) ? ST_RSP : ST_FLUSH_DRAIN;
    end else begin
      adv_inc   = 1'b1;
      adv_state = (op_q == OP_INVAL_ALL) ? ST_INVAL : ST_CHECK;
    end
  end

  // Where to go once every dirty way of the current set has been flushed.
  // FLUSH_INVAL_ALL invalidates the set before advancing; the advance is
  // then taken from INVAL.
  state_e post_state;
  logic   post_inc;
  always_comb begin
    post_state = adv_state;
    post_inc   = adv_inc;
    if (op_q == OP_FLUSH_INVAL_ALL) begin
      post_state = ST_INVAL;
      post_inc   = 1'b0;
    end else if (op_q == OP_FLUSH_NLINE) begin
      post_state = ST_FLUSH_DRAIN;
      post_inc   = 1'b0;
    end
  end

  logic [WAYS-1:0] eval_way;
  always_comb begin
    case (op_q)
      OP_INVAL_NLINE: eval_way = dir_check_hit_way_i;
      OP_FLUSH_NLINE: eval_way = dir_check_hit_way_i & dir_check_dirty_i;
      default:        eval_way = dir_check_dirty_i;
    endcase
  end

  logic [WAYS-1:0] inval_way;
  logic [SET_W-1:0] inval_set;
  always_comb begin
    case (op_q)
      OP_INVAL_NLINE: inval_way = way_q;
      OP_INVAL_SET:   inval_way = mask_q;
      default:        inval_way = '1;
    endcase
    inval_set = ((op_q == OP_INVAL_NLINE) || (op_q == OP_INVAL_SET))
                ? addr_set : set_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_FENCE;
      addr_q    <= '0;
      mask_q    <= '0;
      way_q     <= '0;
      set_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q      <= op_e'(req_op_i);
            addr_q    <= req_addr_i[ADDR_W-1:CL_OFFSET_W];
            mask_q    <= req_way_i;
            way_q     <= '0;
            set_cnt_q <= '0;
            error_q   <= (req_op_i == OP_ILLEGAL);
            case (req_op_i)
              OP_FENCE:   state_q <= ST_FENCE_WAIT;
              OP_ILLEGAL: state_q <= ST_RSP;
              default:    state_q <= ST_DRAIN;
            endcase
          end
        end

        ST_FENCE_WAIT: begin
          if (wbuf_empty_i && rtab_empty_i) state_q <= ST_RSP;
        end

        ST_DRAIN: begin
          if (mshr_empty_i && rtab_empty_i && ctrl_empty_i) begin
            if ((op_q == OP_INVAL_SET) || (op_q == OP_INVAL_ALL))
              state_q <= ST_INVAL;
            else
              state_q <= ST_CHECK;
          end
        end

        ST_CHECK: state_q <= ST_EVAL;

        ST_EVAL: begin
          way_q <= eval_way;
          if (eval_way != '0) begin
            state_q <= (op_q == OP_INVAL_NLINE) ? ST_INVAL : ST_FLUSH;
          end else if (op_q == OP_INVAL_NLINE) begin
            state_q <= ST_RSP;
          end else begin
            state_q <= post_state;
            if (post_inc) set_cnt_q <= set_cnt_q + SET_W'(1);
          end
        end

        ST_FLUSH: begin
          if (flush_req_ready_i) begin
            way_q <= way_rem;
            if (way_rem == '0) begin
              state_q <= post_state;
              if (post_inc) set_cnt_q <= set_cnt_q + SET_W'(1);
            end
          end
        end

        ST_INVAL: begin
          if ((op_q == OP_INVAL_NLINE) || (op_q == OP_INVAL_SET)) begin
            state_q <= ST_RSP;
          end else begin
            state_q <= adv_state;
            if (adv_inc) set_cnt_q <= set_cnt_q + SET_W'(1);
          end
        end

        ST_FLUSH_DRAIN: begin
          if (flush_empty_i) state_q <= ST_RSP;
        end

        ST_RSP: begin
          if (rsp_ready_i) begin
            state_q <= ST_IDLE;
            error_q <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state; payloads are forced to zero
  // whenever their strobe is low.
  always_comb begin
    req_ready_o       = (state_q == ST_IDLE);
    req_wait_o        = (state_q == ST_FENCE_WAIT) || (state_q == ST_DRAIN) ||
                        (state_q == ST_FLUSH_DRAIN);
    rsp_valid_o       = (state_q == ST_RSP);
    rsp_error_o       = (state_q == ST_RSP) && error_q;
    wbuf_flush_all_o  = (state_q == ST_FENCE_WAIT) && rtab_empty_i;

    dir_check_o       = (state_q == ST_CHECK);
    dir_check_set_o   = dir_check_o ? walk_set : '0;
    dir_check_tag_o   = dir_check_o ? addr_tag : '0;

    dir_inval_o       = (state_q == ST_INVAL);
    dir_inval_set_o   = dir_inval_o ? inval_set : '0;
    dir_inval_way_o   = dir_inval_o ? inval_way : '0;

    flush_req_valid_o = (state_q == ST_FLUSH);
    flush_req_set_o   = flush_req_valid_o ? walk_set : '0;
    flush_req_way_o   = flush_req_valid_o ? way_lsb : '0;
    flush_req_inval_o = flush_req_valid_o && (op_q == OP_FLUSH_INVAL_ALL);
  end

endmodule

// File: tb/tb_hpdcache_cmoh_flush.sv
// ----------------------------------------------------------------------------
// tb_hpdcache_cmoh_flush
//   Directed self-checking bench for hpdcache_cmoh_flush (default geometry:
//   4 ways, 64 sets, 6-bit offset, 20-bit tag). A small directory model
//   answers lookups one cycle after dir_check_o; a negedge monitor records
//   strobes and handshakes for the scenario tasks to inspect.
// ----------------------------------------------------------------------------
module tb_hpdcache_cmoh_flush;

  localparam int unsigned WAYS   = 4;
  localparam int unsigned SETS   = 64;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned TAG_W  = 20;
  localparam int unsigned SET_W  = 6;
  localparam int unsigned ADDR_W = TAG_W + SET_W + OFF_W;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              wbuf_empty_i = 1'b1, mshr_empty_i = 1'b1;
  logic              rtab_empty_i = 1'b1, ctrl_empty_i = 1'b1;
  logic              flush_empty_i = 1'b1;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [2:0]        req_op_i = '0;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic [WAYS-1:0]   req_way_i = '0;
  logic              req_wait_o;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic              rsp_error_o;
  logic              wbuf_flush_all_o;
  logic              dir_check_o;
  logic [SET_W-1:0]  dir_check_set_o;
  logic [TAG_W-1:0]  dir_check_tag_o;
  logic [WAYS-1:0]   dir_check_hit_way_i;
  logic [WAYS-1:0]   dir_check_dirty_i;
  logic              dir_inval_o;
  logic [SET_W-1:0]  dir_inval_set_o;
  logic [WAYS-1:0]   dir_inval_way_o;
  logic              flush_req_valid_o;
  logic              flush_req_ready_i = 1'b0;
  logic [SET_W-1:0]  flush_req_set_o;
  logic [WAYS-1:0]   flush_req_way_o;
  logic              flush_req_inval_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  hpdcache_cmoh_flush #(
    .WAYS(WAYS), .SETS(SETS), .CL_OFFSET_W(OFF_W), .TAG_W(TAG_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wbuf_empty_i(wbuf_empty_i), .mshr_empty_i(mshr_empty_i),
    .rtab_empty_i(rtab_empty_i), .ctrl_empty_i(ctrl_empty_i),
    .flush_empty_i(flush_empty_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_way_i(req_way_i),
    .req_wait_o(req_wait_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_error_o(rsp_error_o),
    .wbuf_flush_all_o(wbuf_flush_all_o),
    .dir_check_o(dir_check_o), .dir_check_set_o(dir_check_set_o),
    .dir_check_tag_o(dir_check_tag_o),
    .dir_check_hit_way_i(dir_check_hit_way_i),
    .dir_check_dirty_i(dir_check_dirty_i),
    .dir_inval_o(dir_inval_o), .dir_inval_set_o(dir_inval_set_o),
    .dir_inval_way_o(dir_inval_way_o),
    .flush_req_valid_o(flush_req_valid_o),
    .flush_req_ready_i(flush_req_ready_i),
    .flush_req_set_o(flush_req_set_o), .flush_req_way_o(flush_req_way_o),
    .flush_req_inval_o(flush_req_inval_o)
  );

  // Directory model: one tracked hit set plus a per-set dirty table.
  logic [SET_W-1:0] hit_set = '0;
  logic [WAYS-1:0]  hit_val = '0;
  logic [WAYS-1:0]  dirty_tab [SETS];
  logic [SET_W-1:0] chk_set_q = '0;

  always @(posedge clk_i) chk_set_q <= dir_check_set_o;
  assign dir_check_hit_way_i = (chk_set_q == hit_set) ? hit_val : '0;
  assign dir_check_dirty_i   = dirty_tab[chk_set_q];

  // Negedge monitor
  logic mon_clr = 1'b0;
  int n_chk, n_inv, n_fl, n_wb, n_unstable;
  logic [SET_W-1:0] chk_set [128];
  logic [TAG_W-1:0] chk_tag [128];
  logic [SET_W-1:0] inv_set [128];
  logic [WAYS-1:0]  inv_way [128];
  logic [SET_W-1:0] fl_set  [128];
  logic [WAYS-1:0]  fl_way  [128];
  logic             fl_inv  [128];
  logic             fl_pend;
  logic [SET_W+WAYS:0] fl_prev;

  always @(negedge clk_i) begin
    if (mon_clr) begin
      n_chk = 0; n_inv = 0; n_fl = 0; n_wb = 0; n_unstable = 0;
      fl_pend = 1'b0; fl_prev = '0;
    end else begin
      if (dir_check_o && n_chk < 128) begin
        chk_set[n_chk] = dir_check_set_o; chk_tag[n_chk] = dir_check_tag_o;
        n_chk++;
      end
      if (dir_inval_o && n_inv < 128) begin
        inv_set[n_inv] = dir_inval_set_o; inv_way[n_inv] = dir_inval_way_o;
        n_inv++;
      end
      if (flush_req_valid_o && flush_req_ready_i && n_fl < 128) begin
        fl_set[n_fl] = flush_req_set_o; fl_way[n_fl] = flush_req_way_o;
        fl_inv[n_fl] = flush_req_inval_o;
        n_fl++;
      end
      if (wbuf_flush_all_o) n_wb++;
      if (fl_pend && (!flush_req_valid_o ||
          fl_prev != {flush_req_set_o, flush_req_way_o, flush_req_inval_o}))
        n_unstable++;
      fl_pend = flush_req_valid_o && !flush_req_ready_i;
      fl_prev = {flush_req_set_o, flush_req_way_o, flush_req_inval_o};
    end
  end

  logic tog_en = 1'b0;

  task automatic step();
    @(posedge clk_i);
    #1;
    if (tog_en) flush_req_ready_i = ~flush_req_ready_i;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk_i);
    #1;
    mon_clr = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [TAG_W-1:0] t,
                                                input logic [SET_W-1:0] s);
    return {t, s, 6'h15};
  endfunction

  task automatic issue(input logic [2:0] op, input logic [ADDR_W-1:0] a,
                       input logic [WAYS-1:0] w);
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = a; req_way_i = w;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rsp_valid_o) begin got = 1'b1; break; end
      step();
    end
  endtask

  task automatic ack_rsp();
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [53:0] rest;
    rest = {req_wait_o, rsp_valid_o, rsp_error_o, wbuf_flush_all_o,
            dir_check_o, dir_check_set_o, dir_check_tag_o, dir_inval_o,
            dir_inval_set_o, dir_inval_way_o, flush_req_valid_o,
            flush_req_set_o, flush_req_way_o, flush_req_inval_o};
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
    end
    total++;
    if (rest !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", rest);
    end
  endtask

  task automatic test_fence();
    bit got;
    clear_mon();
    issue(3'd0, '0, '0);
    total++;
    if (wbuf_flush_all_o !== 1'b1 || req_wait_o !== 1'b1) begin
      bad++; $display("FAIL fence_wbuf: got flush=%b wait=%b want 1 1",
                      wbuf_flush_all_o, req_wait_o);
    end
    step();
    wait_rsp(1, got);
    total++;
    if (!got || rsp_error_o !== 1'b0) begin
      bad++; $display("FAIL fence_rsp: got valid=%b err=%b want 1 0",
                      rsp_valid_o, rsp_error_o);
    end
    ack_rsp();
    total++;
    if (n_wb != 1) begin
      bad++; $display("FAIL fence_wbuf_len: got %0d want 1", n_wb);
    end
    total++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      bad++; $display("FAIL fence_idle: got ready=%b valid=%b want 1 0",
                      req_ready_o, rsp_valid_o);
    end
  endtask

  task automatic test_inval_nline();
    bit got;
    hit_set = 6'd5; hit_val = 4'b0100;
    clear_mon();
    issue(3'd1, mk_addr(20'hABCDE, 6'd5), '0);
    wait_rsp(20, got);
    total++;
    if (!got || rsp_error_o !== 1'b0) begin
      bad++; $display("FAIL nline_hit_rsp: got valid=%b err=%b want 1 0",
                      rsp_valid_o, rsp_error_o);
    end
    ack_rsp();
    total++;
    if (n_chk != 1 || chk_set[0] != 6'd5 || chk_tag[0] != 20'hABCDE) begin
      bad++; $display("FAIL nline_check: got n=%0d set=%0d tag=%h want 1 5 abcde",
                      n_chk, chk_set[0], chk_tag[0]);
    end
    total++;
    if (n_inv != 1 || inv_set[0] != 6'd5 || inv_way[0] != 4'b0100) begin
      bad++; $display("FAIL nline_inval: got n=%0d set=%0d way=%b want 1 5 0100",
                      n_inv, inv_set[0], inv_way[0]);
    end
    hit_val = 4'b0000;
    clear_mon();
    issue(3'd1, mk_addr(20'h12345, 6'd5), '0);
    wait_rsp(20, got);
    total++;
    if (!got) begin
      bad++; $display("FAIL nline_miss_rsp: got valid=%b want 1", rsp_valid_o);
    end
    ack_rsp();
    total++;
    if (n_inv != 0 || n_chk != 1) begin
      bad++; $display("FAIL nline_miss_inval: got inval=%0d check=%0d want 0 1",
                      n_inv, n_chk);
    end
  endtask

  task automatic test_inval_all();
    bit got;
    int bad_seq;
    clear_mon();
    issue(3'd3, '0, '0);
    wait_rsp(200, got);
    total++;
    if (!got) begin
      bad++; $display("FAIL inval_all_rsp: got valid=%b want 1", rsp_valid_o);
    end
    ack_rsp();
    total++;
    if (n_inv != 64) begin
      bad++; $display("FAIL inval_all_count: got %0d want 64", n_inv);
    end
    bad_seq = 0;
    for (int i = 0; i < n_inv; i++)
      if (inv_set[i] != SET_W'(i) || inv_way[i] != 4'b1111) bad_seq++;
    total++;
    if (bad_seq != 0 || n_chk != 0) begin
      bad++; $display("FAIL inval_all_order: got %0d bad pulses, %0d checks want 0 0",
                      bad_seq, n_chk);
    end
  endtask

  task automatic test_flush_all();
    bit got;
    int early;
    dirty_tab[3] = 4'b1010;
    flush_empty_i = 1'b0; flush_req_ready_i = 1'b0; tog_en = 1'b1;
    clear_mon();
    issue(3'd5, '0, '0);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (n_fl >= 2) begin got = 1'b1; break; end
      step();
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL flush_reqs_seen: got %0d want 2", n_fl);
    end
    for (int i = 0; i < 300; i++) begin
      if (req_wait_o) break;
      step();
    end
    early = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid_o) early++;
      step();
    end
    total++;
    if (early != 0 || req_wait_o !== 1'b1) begin
      bad++; $display("FAIL flush_drain_hold: got early=%0d wait=%b want 0 1",
                      early, req_wait_o);
    end
    flush_empty_i = 1'b1;
    wait_rsp(5, got);
    total++;
    if (!got || rsp_error_o !== 1'b0) begin
      bad++; $display("FAIL flush_rsp: got valid=%b err=%b want 1 0",
                      rsp_valid_o, rsp_error_o);
    end
    ack_rsp();
    tog_en = 1'b0; flush_req_ready_i = 1'b0;
    total++;
    if (n_fl != 2 || fl_way[0] != 4'b0010 || fl_way[1] != 4'b1000) begin
      bad++; $display("FAIL flush_ways: got n=%0d w0=%b w1=%b want 2 0010 1000",
                      n_fl, fl_way[0], fl_way[1]);
    end
    total++;
    if (fl_set[0] != 6'd3 || fl_set[1] != 6'd3 || fl_inv[0] || fl_inv[1]) begin
      bad++; $display("FAIL flush_set_inval: got s=%0d,%0d inv=%b%b want 3,3 00",
                      fl_set[0], fl_set[1], fl_inv[0], fl_inv[1]);
    end
    total++;
    if (n_unstable != 0 || n_chk != 64 || n_inv != 0) begin
      bad++; $display("FAIL flush_misc: got unstable=%0d checks=%0d inval=%0d want 0 64 0",
                      n_unstable, n_chk, n_inv);
    end
    dirty_tab[3] = '0;
  endtask

  task automatic test_inval_set_drain();
    bit got;
    int no_wait, busy_ready;
    mshr_empty_i = 1'b0;
    clear_mon();
    issue(3'd2, mk_addr(20'h00777, 6'd9), 4'b0110);
    no_wait = 0; busy_ready = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_wait_o !== 1'b1) no_wait++;
      if (req_ready_o !== 1'b0) busy_ready++;
      step();
    end
    total++;
    if (no_wait != 0 || busy_ready != 0) begin
      bad++; $display("FAIL set_drain_wait: got nowait=%0d ready=%0d want 0 0",
                      no_wait, busy_ready);
    end
    total++;
    if (n_chk != 0 || n_inv != 0) begin
      bad++; $display("FAIL set_drain_quiet: got check=%0d inval=%0d want 0 0",
                      n_chk, n_inv);
    end
    mshr_empty_i = 1'b1;
    wait_rsp(10, got);
    total++;
    if (!got) begin
      bad++; $display("FAIL set_rsp: got valid=%b want 1", rsp_valid_o);
    end
    ack_rsp();
    total++;
    if (n_inv != 1 || inv_set[0] != 6'd9 || inv_way[0] != 4'b0110) begin
      bad++; $display("FAIL set_inval: got n=%0d set=%0d way=%b want 1 9 0110",
                      n_inv, inv_set[0], inv_way[0]);
    end
    clear_mon();
    issue(3'd2, mk_addr(20'h00001, 6'd63), 4'b0000);
    wait_rsp(10, got);
    ack_rsp();
    total++;
    if (!got || n_inv != 1 || inv_set[0] != 6'd63 || inv_way[0] != 4'b0000) begin
      bad++; $display("FAIL set_zero_mask: got rsp=%b n=%0d set=%0d way=%b want 1 1 63 0000",
                      got, n_inv, inv_set[0], inv_way[0]);
    end
  endtask

  task automatic test_illegal_and_reset();
    bit got;
    int seen;
    logic [53:0] rest;
    clear_mon();
    issue(3'd7, mk_addr(20'hFFFFF, 6'd1), 4'b1111);
    wait_rsp(3, got);
    total++;
    if (!got || rsp_error_o !== 1'b1) begin
      bad++; $display("FAIL illegal_rsp: got valid=%b err=%b want 1 1",
                      rsp_valid_o, rsp_error_o);
    end
    ack_rsp();
    total++;
    if (n_chk != 0 || n_inv != 0 || n_fl != 0 || n_wb != 0) begin
      bad++; $display("FAIL illegal_side: got chk=%0d inv=%0d fl=%0d wb=%0d want 0 0 0 0",
                      n_chk, n_inv, n_fl, n_wb);
    end
    dirty_tab[0] = 4'b0001;
    flush_req_ready_i = 1'b0;
    issue(3'd5, '0, '0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (flush_req_valid_o) begin got = 1'b1; break; end
      step();
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL rst_reach_flush: got valid=%b want 1", flush_req_valid_o);
    end
    rst_ni = 1'b0;
    #1;
    rest = {req_wait_o, rsp_valid_o, rsp_error_o, wbuf_flush_all_o,
            dir_check_o, dir_check_set_o, dir_check_tag_o, dir_inval_o,
            dir_inval_set_o, dir_inval_way_o, flush_req_valid_o,
            flush_req_set_o, flush_req_way_o, flush_req_inval_o};
    total++;
    if (rest !== '0 || req_ready_o !== 1'b1) begin
      bad++; $display("FAIL rst_mid_flush: got outs=%h ready=%b want 0 1",
                      rest, req_ready_o);
    end
    #4;
    rst_ni = 1'b1;
    dirty_tab[0] = '0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid_o || !req_ready_o || flush_req_valid_o) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_silent: got %0d busy cycles want 0", seen);
    end
  endtask

  initial begin
    for (int i = 0; i < SETS; i++) dirty_tab[i] = '0;
    mon_clr = 1'b1;
    #12;
    test_reset();
    rst_ni = 1'b1;
    step();
    mon_clr = 1'b0;
    test_fence();
    test_inval_nline();
    test_inval_all();
    test_flush_all();
    test_inval_set_drain();
    test_illegal_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
